iob_fifo_dp_ctrl: RTL and testbench

//   Synchronous FIFO controller driving an external iob_ram_dp as storage: port A is write-only, port B read-only.

---
 rtl/iob_fifo_dp_ctrl_if.sv | 37 +++
 rtl/iob_fifo_dp_ctrl.sv | 64 ++++++
 tb/tb_iob_fifo_dp_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/iob_fifo_dp_ctrl_if.sv
// iob_fifo_dp_ctrl_if: producer/consumer handshake and RAM-side signals of the dual-port FIFO controller
//   w_en, w_data, w_full                   : producer side
//   r_en, r_data, r_valid, r_empty, level  : consumer side and fill level
//   ram_enA, ram_weA, ram_addrA, ram_dinA  : RAM port A (write only)
//   ram_enB, ram_weB, ram_addrB, ram_doutB : RAM port B (read only)
//   modport slave is the controller's view; modport master is the parent/bench view.
interface iob_fifo_dp_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic [ADDR_W:0]   level;
  logic              ram_enA;
  logic              ram_weA;
  logic [ADDR_W-1:0] ram_addrA;
  logic [DATA_W-1:0] ram_dinA;
  logic              ram_enB;
  logic              ram_weB;
  logic [ADDR_W-1:0] ram_addrB;
  logic [DATA_W-1:0] ram_doutB;
  modport slave (
    input  w_en, w_data, r_en, ram_doutB,
    output w_full, r_data, r_valid, r_empty, level,
           ram_enA, ram_weA, ram_addrA, ram_dinA, ram_enB, ram_weB, ram_addrB
  );
  modport master (
    output w_en, w_data, r_en, ram_doutB,
    input  w_full, r_data, r_valid, r_empty, level,
           ram_enA, ram_weA, ram_addrA, ram_dinA, ram_enB, ram_weB, ram_addrB
  );
endinterface

// File: rtl/iob_fifo_dp_ctrl.sv
// iob_fifo_dp_ctrl: synchronous FIFO controller using an external dual-port RAM (A write, B read)
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : iob_fifo_dp_ctrl_if.slave (handshake, level, flags, RAM ports)
//   Optional macro IOB_FIFO_DP_CTRL_ERR_EN adds err_clr (in), w_ovf and r_udf (sticky error outputs).
module iob_fifo_dp_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef IOB_FIFO_DP_CTRL_ERR_EN
  input  logic err_clr,
  output logic w_ovf,
  output logic r_udf,
`endif
  iob_fifo_dp_ctrl_if.slave bus
);
  logic [ADDR_W:0] w_ptr, r_ptr, w_ptr_nx, r_ptr_nx, level_nx;
  logic w_acc, r_acc;
  // Full blocks the write and empty blocks the read, so a both-request never
  // lets port A and port B touch the same address in the same cycle.
  assign w_acc = bus.w_en & ~bus.w_full;
  assign r_acc = bus.r_en & ~bus.r_empty;
  assign w_ptr_nx = w_ptr + (ADDR_W+1)'(w_acc);
  assign r_ptr_nx = r_ptr + (ADDR_W+1)'(r_acc);
  assign level_nx = bus.level + (ADDR_W+1)'(w_acc) - (ADDR_W+1)'(r_acc);
  assign bus.ram_enA = w_acc;
  assign bus.ram_weA = w_acc;
  assign bus.ram_addrA = w_ptr[ADDR_W-1:0];
  assign bus.ram_dinA = bus.w_data;
  assign bus.ram_enB = r_acc;
  assign bus.ram_weB = 1'b0;
  assign bus.ram_addrB = r_ptr[ADDR_W-1:0];
  assign bus.r_data = bus.ram_doutB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      bus.level <= '0;
      bus.r_empty <= 1'b1;
      bus.w_full <= 1'b0;
      bus.r_valid <= 1'b0;
    end else begin
      w_ptr <= w_ptr_nx;
      r_ptr <= r_ptr_nx;
      bus.level <= level_nx;
      bus.r_empty <= w_ptr_nx == r_ptr_nx;
      // Full: same RAM address, opposite wrap bit.
      bus.w_full <= w_ptr_nx == {~r_ptr_nx[ADDR_W], r_ptr_nx[ADDR_W-1:0]};
      bus.r_valid <= r_acc;
    end
`ifdef IOB_FIFO_DP_CTRL_ERR_EN
  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      w_ovf <= (bus.w_en & bus.w_full) | (w_ovf & ~err_clr);
      r_udf <= (bus.r_en & bus.r_empty) | (r_udf & ~err_clr);
    end
`endif
endmodule

// File: tb/tb_iob_fifo_dp_ctrl.sv
// tb_iob_fifo_dp_ctrl: directed self-checking bench for iob_fifo_dp_ctrl with a behavioural dual-port RAM
module tb_iob_fifo_dp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int nvec = 0;
  int nerr = 0;
  logic [7:0] mem [16];
  iob_fifo_dp_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();
`ifdef IOB_FIFO_DP_CTRL_ERR_EN
  logic err_clr = 1'b0;
  logic w_ovf, r_udf;
`endif
  iob_fifo_dp_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef IOB_FIFO_DP_CTRL_ERR_EN
    .err_clr(err_clr),
    .w_ovf(w_ovf),
    .r_udf(r_udf),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (bus.ram_enA && bus.ram_weA) mem[bus.ram_addrA] <= bus.ram_dinA;
    if (bus.ram_enB) bus.ram_doutB <= mem[bus.ram_addrB];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rst_state(input string tag);
    chk({tag, "_empty"}, 32'(bus.r_empty), 1);
    chk({tag, "_full"}, 32'(bus.w_full), 0);
    chk({tag, "_level"}, 32'(bus.level), 0);
    chk({tag, "_valid"}, 32'(bus.r_valid), 0);
  endtask
  initial begin
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.w_data = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_rst_state("rst");
    chk("rst_enA", 32'(bus.ram_enA), 0);
    chk("rst_enB", 32'(bus.ram_enB), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // reads against an empty FIFO are ignored
    bus.r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("idle_enB", 32'(bus.ram_enB), 0);
      tick();
      chk("idle_valid", 32'(bus.r_valid), 0);
    end
    bus.r_en = 1'b0;
    chk_rst_state("idle");
    // fill to full
    bus.w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.w_data = 8'(32'h20 + i);
      #1 chk("fill_enA", 32'(bus.ram_enA), 1);
      chk("fill_addrA", 32'(bus.ram_addrA), 32'(i));
      tick();
    end
    chk("full_flag", 32'(bus.w_full), 1);
    chk("full_level", 32'(bus.level), 16);
    bus.w_data = 8'hEE;
    #1 chk("ovf_enA", 32'(bus.ram_enA), 0);
    tick();
    bus.w_en = 1'b0;
    chk("ovf_level", 32'(bus.level), 16);
    chk("ovf_full", 32'(bus.w_full), 1);
    chk("ovf_addrA", 32'(bus.ram_addrA), 0);
    // drain in order
    bus.r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 chk("drain_addrB", 32'(bus.ram_addrB), 32'(i));
      tick();
      chk("drain_valid", 32'(bus.r_valid), 1);
      chk("drain_data", 32'(bus.r_data), 32'h20 + 32'(i));
    end
    bus.r_en = 1'b0;
    chk("drain_empty", 32'(bus.r_empty), 1);
    chk("drain_level", 32'(bus.level), 0);
    tick();
    chk("drain_valid_off", 32'(bus.r_valid), 0);
    // pre-fill 8, then stream 40 cycles through the pointer wrap
    bus.w_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.w_data = 8'(32'h40 + i);
      tick();
    end
    chk("pre_level", 32'(bus.level), 8);
    bus.r_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.w_data = 8'(32'h48 + k);
      tick();
      chk("strm_valid", 32'(bus.r_valid), 1);
      chk("strm_data", 32'(bus.r_data), 32'h40 + 32'(k));
      chk("strm_level", 32'(bus.level), 8);
    end
    bus.r_en = 1'b0;
    // top up to full (holds 0x68..0x77)
    for (int i = 0; i < 8; i++) begin
      bus.w_data = 8'(32'h70 + i);
      tick();
    end
    chk("full2_flag", 32'(bus.w_full), 1);
    chk("full2_level", 32'(bus.level), 16);
    // full + both: read wins, write dropped
    bus.r_en = 1'b1;
    bus.w_data = 8'hEE;
    #1 chk("fb_enA", 32'(bus.ram_enA), 0);
    chk("fb_enB", 32'(bus.ram_enB), 1);
    tick();
    bus.w_en = 1'b0;
    chk("fb_level", 32'(bus.level), 15);
    chk("fb_full", 32'(bus.w_full), 0);
    chk("fb_data", 32'(bus.r_data), 32'h68);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("fb_drain", 32'(bus.r_data), 32'h68 + 32'(i));
    end
    chk("eb_pre_empty", 32'(bus.r_empty), 1);
    // empty + both: write wins, read dropped
    bus.w_en = 1'b1;
    bus.w_data = 8'h99;
    #1 chk("eb_enA", 32'(bus.ram_enA), 1);
    chk("eb_enB", 32'(bus.ram_enB), 0);
    tick();
    bus.w_en = 1'b0;
    chk("eb_level", 32'(bus.level), 1);
    chk("eb_valid", 32'(bus.r_valid), 0);
    chk("eb_empty", 32'(bus.r_empty), 0);
    tick();
    bus.r_en = 1'b0;
    chk("eb_data", 32'(bus.r_data), 32'h99);
    chk("eb_valid2", 32'(bus.r_valid), 1);
    // reset mid-operation with level 5 and r_valid in flight
    bus.w_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.w_data = 8'(32'hA0 + i);
      tick();
    end
    bus.w_en = 1'b0;
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    chk("mid_level", 32'(bus.level), 5);
    chk("mid_valid", 32'(bus.r_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_rst_state("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_addrA", 32'(bus.ram_addrA), 0);
    chk("post_addrB", 32'(bus.ram_addrB), 0);
`ifdef IOB_FIFO_DP_CTRL_ERR_EN
    chk("err_rst_ovf", 32'(w_ovf), 0);
    chk("err_rst_udf", 32'(r_udf), 0);
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    chk("udf_set", 32'(r_udf), 1);
    tick();
    chk("udf_hold", 32'(r_udf), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("udf_clr", 32'(r_udf), 0);
    bus.w_en = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("ovf_pre", 32'(w_ovf), 0);
    tick();
    bus.w_en = 1'b0;
    chk("ovf_set", 32'(w_ovf), 1);
    tick();
    chk("ovf_hold", 32'(w_ovf), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(w_ovf), 0);
    bus.w_en = 1'b1;
    err_clr = 1'b1;
    tick();
    bus.w_en = 1'b0;
    err_clr = 1'b0;
    chk("ovf_set_wins", 32'(w_ovf), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
